// File: rtl/prt_scaler_pkg.sv
// Shared types and constants for the scaler sequencing agent.
package prt_scaler_pkg;

  localparam int unsigned P_FRAC_W   = 3;
  localparam int unsigned P_COEF_ONE = 64;

  localparam logic [3:0] SEL_L0_BASE = 4'd0;
  localparam logic [3:0] SEL_L1_BASE = 4'd5;

  typedef enum logic [1:0] {IDLE, RUN, DONE} agnt_state_t;

  // Per-output-pixel taps and Q6 bilinear weights.
  typedef struct packed {
    logic [0:3][3:0] sel;
    logic [0:3][7:0] coef;
  } pix_res_t;

  // Out-of-range steps behave as a unity step.
  function automatic logic [3:0] norm_step(input logic [3:0] step);
    return (step == 4'd0 || step > 4'd8) ? 4'd8 : step;
  endfunction

endpackage

// File: rtl/prt_scaler_agnt_if.sv
// Control/result bundle between the line sequencer and the scaler agent.
interface prt_scaler_agnt_if #(
  parameter int unsigned P_GRP_W = 12
);

  logic               CTL_RUN_IN;
  logic               LINE_STRT_IN;
  logic [3:0]         H_STEP_IN;
  logic [2:0]         H_PHASE_IN;
  logic [2:0]         V_PHASE_IN;
  logic [P_GRP_W-1:0] H_GRP_IN;
  logic               SLW_VLD_IN;
  logic [2:0]         SLW_ADV_OUT;
  logic               AGNT_DE_OUT;
  logic [63:0]        MUX_SEL_OUT;
  logic [31:0]        COEF_P0_OUT;
  logic [31:0]        COEF_P1_OUT;
  logic [31:0]        COEF_P2_OUT;
  logic [31:0]        COEF_P3_OUT;
  logic               LINE_DONE_OUT;

  modport master (
    output CTL_RUN_IN, LINE_STRT_IN, H_STEP_IN, H_PHASE_IN, V_PHASE_IN, H_GRP_IN, SLW_VLD_IN,
    input  SLW_ADV_OUT, AGNT_DE_OUT, MUX_SEL_OUT, COEF_P0_OUT, COEF_P1_OUT, COEF_P2_OUT,
           COEF_P3_OUT, LINE_DONE_OUT
  );

  modport slave (
    input  CTL_RUN_IN, LINE_STRT_IN, H_STEP_IN, H_PHASE_IN, V_PHASE_IN, H_GRP_IN, SLW_VLD_IN,
    output SLW_ADV_OUT, AGNT_DE_OUT, MUX_SEL_OUT, COEF_P0_OUT, COEF_P1_OUT, COEF_P2_OUT,
           COEF_P3_OUT, LINE_DONE_OUT
  );

endinterface

// File: rtl/prt_scaler_agnt_phs.sv
// Per-pixel phase decode: tap selects and bilinear weights for pixel n of a group.
module prt_scaler_agnt_phs
  import prt_scaler_pkg::*;
(
  input  logic [2:0] acc,
  input  logic [1:0] n,
  input  logic [3:0] step,
  input  logic [2:0] fy,
  output pix_res_t   res
);

  logic [4:0] pos;
  logic [3:0] tap;
  logic [7:0] wx0, wx1, wy0, wy1;
  logic [7:0] c1, c2, c3;

  always_comb begin
    pos = {2'b00, acc} + ({3'b000, n} * {1'b0, step});
    tap = {2'b00, pos[4:P_FRAC_W]};
    wx1 = {5'd0, pos[P_FRAC_W-1:0]};
    wx0 = 8'd8 - wx1;
    wy1 = {5'd0, fy};
    wy0 = 8'd8 - wy1;

    res.sel[0] = SEL_L0_BASE + tap;
    res.sel[1] = SEL_L0_BASE + tap + 4'd1;
    res.sel[2] = SEL_L1_BASE + tap;
    res.sel[3] = SEL_L1_BASE + tap + 4'd1;

    c1 = wx1 * wy0;
    c2 = wx0 * wy1;
    c3 = wx1 * wy1;
    // The four weights always sum to one in Q6, so c0 falls out of the others.
    res.coef[0] = 8'(P_COEF_ONE) - c1 - c2 - c3;
    res.coef[1] = c1;
    res.coef[2] = c2;
    res.coef[3] = c3;
  end

endmodule

// File: rtl/prt_scaler_agnt.sv
// Horizontal phase sequencer for one output line of the 4-pixel bilinear scaler kernel.
module prt_scaler_agnt
  import prt_scaler_pkg::*;
#(
  parameter int unsigned P_PPC      = 4,
  parameter int unsigned P_GRP_W    = 12,
  parameter int unsigned P_COEF_DLY = 1
) (
  input logic              CLK_IN,
  input logic              RST_IN,
  prt_scaler_agnt_if.slave bus
);

  if (P_PPC != 4) begin : g_bad_ppc
    $error("prt_scaler_agnt: P_PPC must be 4");
  end
  if (P_COEF_DLY > 3) begin : g_bad_dly
    $error("prt_scaler_agnt: P_COEF_DLY must be 0..3");
  end

  agnt_state_t        state;
  logic [3:0]         step_q;
  logic [2:0]         acc_q;
  logic [2:0]         fy_q;
  logic [P_GRP_W-1:0] grp_q;
  logic               de_q;
  logic [2:0]         adv_q;
  logic [63:0]        sel_q;
  logic               done_q;

  pix_res_t     res [P_PPC];
  logic [63:0]  sel_nxt;
  logic [127:0] coef_nxt;
  logic [5:0]   acc_sum;
  logic         issue;

  logic [127:0] coef_pipe [P_COEF_DLY+1];

  for (genvar n = 0; n < P_PPC; n++) begin : g_phs
    prt_scaler_agnt_phs u_phs (
      .acc  (acc_q),
      .n    (2'(n)),
      .step (step_q),
      .fy   (fy_q),
      .res  (res[n])
    );
  end

  assign acc_sum = {3'b000, acc_q} + {step_q, 2'b00};
  assign issue   = (state == RUN) && bus.CTL_RUN_IN && bus.SLW_VLD_IN;

  always_comb begin
    sel_nxt  = '0;
    coef_nxt = '0;
    for (int unsigned n = 0; n < P_PPC; n++) begin
      for (int unsigned k = 0; k < 4; k++) begin
        sel_nxt[(4*n+k)*4 +: 4]  = res[n].sel[k];
        coef_nxt[32*n+8*k +: 8]  = res[n].coef[k];
      end
    end
  end

  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      state  <= IDLE;
      step_q <= 4'd8;
      acc_q  <= '0;
      fy_q   <= '0;
      grp_q  <= '0;
      de_q   <= 1'b0;
      adv_q  <= '0;
      sel_q  <= '0;
      done_q <= 1'b0;
    end else begin
      de_q   <= 1'b0;
      adv_q  <= '0;
      done_q <= 1'b0;
      if (!bus.CTL_RUN_IN) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (bus.LINE_STRT_IN) begin
              step_q <= norm_step(bus.H_STEP_IN);
              acc_q  <= bus.H_PHASE_IN;
              fy_q   <= bus.V_PHASE_IN;
              grp_q  <= bus.H_GRP_IN;
              // An empty line completes immediately without entering RUN.
              if (bus.H_GRP_IN == '0) done_q <= 1'b1;
              else                    state  <= RUN;
            end
          end
          RUN: begin
            if (bus.SLW_VLD_IN) begin
              de_q  <= 1'b1;
              adv_q <= acc_sum[5:3];
              acc_q <= acc_sum[2:0];
              sel_q <= sel_nxt;
              grp_q <= grp_q - P_GRP_W'(1);
              if (grp_q == P_GRP_W'(1)) state <= DONE;
            end
          end
          DONE: begin
            done_q <= 1'b1;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Stage 0 tracks the last issued group; later stages free-run so aborted lines still drain.
  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      for (int unsigned k = 0; k <= P_COEF_DLY; k++) coef_pipe[k] <= '0;
    end else begin
      if (issue) coef_pipe[0] <= coef_nxt;
      for (int unsigned k = 1; k <= P_COEF_DLY; k++) coef_pipe[k] <= coef_pipe[k-1];
    end
  end

  assign bus.AGNT_DE_OUT   = de_q;
  assign bus.SLW_ADV_OUT   = adv_q;
  assign bus.MUX_SEL_OUT   = sel_q;
  assign bus.LINE_DONE_OUT = done_q;
  assign bus.COEF_P0_OUT   = coef_pipe[P_COEF_DLY][31:0];
  assign bus.COEF_P1_OUT   = coef_pipe[P_COEF_DLY][63:32];
  assign bus.COEF_P2_OUT   = coef_pipe[P_COEF_DLY][95:64];
  assign bus.COEF_P3_OUT   = coef_pipe[P_COEF_DLY][127:96];

endmodule

// File: tb/tb_prt_scaler_agnt.sv
// Self-checking bench for prt_scaler_agnt: directed scenarios plus randomized lines vs a model.
module tb_prt_scaler_agnt;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  prt_scaler_agnt_if #(.P_GRP_W(12)) bus1 ();
  prt_scaler_agnt_if #(.P_GRP_W(12)) bus2 ();

  assign bus2.CTL_RUN_IN   = bus1.CTL_RUN_IN;
  assign bus2.LINE_STRT_IN = bus1.LINE_STRT_IN;
  assign bus2.H_STEP_IN    = bus1.H_STEP_IN;
  assign bus2.H_PHASE_IN   = bus1.H_PHASE_IN;
  assign bus2.V_PHASE_IN   = bus1.V_PHASE_IN;
  assign bus2.H_GRP_IN     = bus1.H_GRP_IN;
  assign bus2.SLW_VLD_IN   = bus1.SLW_VLD_IN;

  prt_scaler_agnt #(.P_PPC(4), .P_GRP_W(12), .P_COEF_DLY(1)) dut (
    .CLK_IN (clk),
    .RST_IN (rst_n),
    .bus    (bus1)
  );

  prt_scaler_agnt #(.P_PPC(4), .P_GRP_W(12), .P_COEF_DLY(2)) dut2 (
    .CLK_IN (clk),
    .RST_IN (rst_n),
    .bus    (bus2)
  );

  logic [127:0] coef1, coef2;
  assign coef1 = {bus1.COEF_P3_OUT, bus1.COEF_P2_OUT, bus1.COEF_P1_OUT, bus1.COEF_P0_OUT};
  assign coef2 = {bus2.COEF_P3_OUT, bus2.COEF_P2_OUT, bus2.COEF_P1_OUT, bus2.COEF_P0_OUT};

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: line progress plus the coefficient history seen at the outputs.
  bit           m_busy, m_tail;
  int           m_left, m_acc, m_step, m_fy;
  logic         e_de, e_done;
  logic [2:0]   e_adv;
  logic [63:0]  e_sel;
  logic [127:0] m_cur, m_p1, m_p2;

  task automatic reset_model();
    m_busy = 0; m_tail = 0; m_left = 0; m_acc = 0; m_step = 8; m_fy = 0;
    e_de = 0; e_done = 0; e_adv = '0; e_sel = '0;
    m_cur = '0; m_p1 = '0; m_p2 = '0;
  endtask

  task automatic model_step();
    int s, p, tap, fx;
    if (!rst_n) begin
      reset_model();
      return;
    end
    m_p2 = m_p1;
    m_p1 = m_cur;
    e_de = 0; e_adv = '0; e_done = 0;
    if (!bus1.CTL_RUN_IN) begin
      m_busy = 0; m_tail = 0;
    end else if (m_tail) begin
      e_done = 1; m_tail = 0;
    end else if (m_busy) begin
      if (bus1.SLW_VLD_IN) begin
        for (int n = 0; n < 4; n++) begin
          p = m_acc + n * m_step;
          tap = p / 8;
          fx = p % 8;
          e_sel[16*n +: 16] = {4'(tap + 6), 4'(tap + 5), 4'(tap + 1), 4'(tap)};
          m_cur[32*n +: 32] = {8'(fx * m_fy), 8'((8 - fx) * m_fy), 8'(fx * (8 - m_fy)),
                               8'((8 - fx) * (8 - m_fy))};
        end
        s = m_acc + 4 * m_step;
        e_de = 1;
        e_adv = 3'(s / 8);
        m_acc = s % 8;
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_tail = 1;
        end
      end
    end else if (bus1.LINE_STRT_IN) begin
      m_step = (bus1.H_STEP_IN == 0 || bus1.H_STEP_IN > 8) ? 8 : int'(bus1.H_STEP_IN);
      m_acc  = int'(bus1.H_PHASE_IN);
      m_fy   = int'(bus1.V_PHASE_IN);
      if (bus1.H_GRP_IN == 0) e_done = 1;
      else begin
        m_busy = 1; m_left = int'(bus1.H_GRP_IN);
      end
    end
  endtask

  // One clock: model sees the inputs at the edge, caller checks at the following negedge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus1.CTL_RUN_IN = 1'b1; bus1.LINE_STRT_IN = 1'b0; bus1.SLW_VLD_IN = 1'b0;
    bus1.H_STEP_IN = 4'd8; bus1.H_PHASE_IN = '0; bus1.V_PHASE_IN = '0; bus1.H_GRP_IN = 12'd1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic start_line(input logic [3:0] st, input logic [2:0] ph, input logic [2:0] fy,
                            input logic [11:0] grp);
    bus1.LINE_STRT_IN = 1'b1;
    bus1.H_STEP_IN = st; bus1.H_PHASE_IN = ph; bus1.V_PHASE_IN = fy; bus1.H_GRP_IN = grp;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (bus1.AGNT_DE_OUT !== 1'b0) $display("FAIL rst_de got %0b exp 0", bus1.AGNT_DE_OUT); else n_pass++;
    n_chk++; if (bus1.SLW_ADV_OUT !== 3'd0) $display("FAIL rst_adv got %0d exp 0", bus1.SLW_ADV_OUT); else n_pass++;
    n_chk++; if (bus1.MUX_SEL_OUT !== 64'd0) $display("FAIL rst_sel got %h exp 0", bus1.MUX_SEL_OUT); else n_pass++;
    n_chk++; if (bus1.LINE_DONE_OUT !== 1'b0) $display("FAIL rst_done got %0b exp 0", bus1.LINE_DONE_OUT); else n_pass++;
    n_chk++; if (coef1 !== 128'd0) $display("FAIL rst_coef got %h exp 0", coef1); else n_pass++;
    n_chk++; if (coef2 !== 128'd0) $display("FAIL rst_coef2 got %h exp 0", coef2); else n_pass++;
  endtask

  task automatic test_step8();
    do_reset();
    start_line(4'd8, 3'd0, 3'd0, 12'd3);
    bus1.SLW_VLD_IN = 1'b1;
    tick();
    bus1.LINE_STRT_IN = 1'b0;
    n_chk++; if (bus1.AGNT_DE_OUT !== 1'b0) $display("FAIL s8_de_lat got %0b exp 0", bus1.AGNT_DE_OUT); else n_pass++;
    for (int g = 0; g < 3; g++) begin
      tick();
      n_chk++; if (bus1.AGNT_DE_OUT !== 1'b1) $display("FAIL s8_de g%0d got %0b exp 1", g, bus1.AGNT_DE_OUT); else n_pass++;
      n_chk++; if (bus1.MUX_SEL_OUT !== 64'h9843_8732_7621_6510) $display("FAIL s8_sel g%0d got %h exp 9843873276216510", g, bus1.MUX_SEL_OUT); else n_pass++;
      n_chk++; if (bus1.SLW_ADV_OUT !== 3'd4) $display("FAIL s8_adv g%0d got %0d exp 4", g, bus1.SLW_ADV_OUT); else n_pass++;
      n_chk++; if (bus1.LINE_DONE_OUT !== 1'b0) $display("FAIL s8_done_early g%0d got %0b exp 0", g, bus1.LINE_DONE_OUT); else n_pass++;
      if (g > 0) begin
        n_chk++; if (coef1 !== {4{32'h40}}) $display("FAIL s8_coef g%0d got %h exp 4x00000040", g, coef1); else n_pass++;
      end
    end
    tick();
    n_chk++; if (bus1.LINE_DONE_OUT !== 1'b1) $display("FAIL s8_done got %0b exp 1", bus1.LINE_DONE_OUT); else n_pass++;
    n_chk++; if (bus1.AGNT_DE_OUT !== 1'b0) $display("FAIL s8_de_end got %0b exp 0", bus1.AGNT_DE_OUT); else n_pass++;
    n_chk++; if (coef1 !== {4{32'h40}}) $display("FAIL s8_coef_last got %h exp 4x00000040", coef1); else n_pass++;
    tick();
    n_chk++; if (bus1.LINE_DONE_OUT !== 1'b0) $display("FAIL s8_done_pulse got %0b exp 0", bus1.LINE_DONE_OUT); else n_pass++;
  endtask

  task automatic test_step4();
    do_reset();
    start_line(4'd4, 3'd0, 3'd0, 12'd1);
    bus1.SLW_VLD_IN = 1'b1;
    tick();
    bus1.LINE_STRT_IN = 1'b0;
    tick();
    n_chk++; if (bus1.MUX_SEL_OUT !== 64'h7621_7621_6510_6510) $display("FAIL s4_sel got %h exp 7621762165106510", bus1.MUX_SEL_OUT); else n_pass++;
    n_chk++; if (bus1.SLW_ADV_OUT !== 3'd2) $display("FAIL s4_adv got %0d exp 2", bus1.SLW_ADV_OUT); else n_pass++;
    tick();
    n_chk++; if (bus1.COEF_P0_OUT !== 32'h0000_0040) $display("FAIL s4_coef0 got %h exp 00000040", bus1.COEF_P0_OUT); else n_pass++;
    n_chk++; if (bus1.COEF_P1_OUT !== 32'h0000_2020) $display("FAIL s4_coef1 got %h exp 00002020", bus1.COEF_P1_OUT); else n_pass++;
    n_chk++; if (bus1.LINE_DONE_OUT !== 1'b1) $display("FAIL s4_done got %0b exp 1", bus1.LINE_DONE_OUT); else n_pass++;
  endtask

  task automatic test_step3();
    do_reset();
    start_line(4'd3, 3'd0, 3'd4, 12'd2);
    bus1.SLW_VLD_IN = 1'b1;
    tick();
    bus1.LINE_STRT_IN = 1'b0;
    tick();
    n_chk++; if (bus1.SLW_ADV_OUT !== 3'd1) $display("FAIL s3_adv0 got %0d exp 1", bus1.SLW_ADV_OUT); else n_pass++;
    tick();
    n_chk++; if (bus1.SLW_ADV_OUT !== 3'd2) $display("FAIL s3_adv1 got %0d exp 2", bus1.SLW_ADV_OUT); else n_pass++;
    n_chk++; if (bus1.COEF_P0_OUT !== 32'h0020_0020) $display("FAIL s3_coef_g0 got %h exp 00200020", bus1.COEF_P0_OUT); else n_pass++;
    tick();
    n_chk++; if (bus1.COEF_P0_OUT !== 32'h1010_1010) $display("FAIL s3_coef_g1 got %h exp 10101010", bus1.COEF_P0_OUT); else n_pass++;
    n_chk++; if (bus1.LINE_DONE_OUT !== 1'b1) $display("FAIL s3_done got %0b exp 1", bus1.LINE_DONE_OUT); else n_pass++;
  endtask

  task automatic test_stall();
    logic [63:0] held;
    do_reset();
    start_line(4'd3, 3'd5, 3'd2, 12'd4);
    bus1.SLW_VLD_IN = 1'b1;
    held = '0;
    for (int c = 0; c < 11; c++) begin
      tick();
      bus1.LINE_STRT_IN = 1'b0;
      n_chk++; if (bus1.AGNT_DE_OUT !== e_de) $display("FAIL st_de c%0d got %0b exp %0b", c, bus1.AGNT_DE_OUT, e_de); else n_pass++;
      n_chk++; if (bus1.SLW_ADV_OUT !== e_adv) $display("FAIL st_adv c%0d got %0d exp %0d", c, bus1.SLW_ADV_OUT, e_adv); else n_pass++;
      n_chk++; if (bus1.MUX_SEL_OUT !== e_sel) $display("FAIL st_sel c%0d got %h exp %h", c, bus1.MUX_SEL_OUT, e_sel); else n_pass++;
      n_chk++; if (bus1.LINE_DONE_OUT !== e_done) $display("FAIL st_done c%0d got %0b exp %0b", c, bus1.LINE_DONE_OUT, e_done); else n_pass++;
      n_chk++; if (coef1 !== m_p1) $display("FAIL st_coef c%0d got %h exp %h", c, coef1, m_p1); else n_pass++;
      if (c >= 2 && c <= 4) begin
        n_chk++; if (bus1.AGNT_DE_OUT !== 1'b0 || bus1.SLW_ADV_OUT !== 3'd0 || bus1.MUX_SEL_OUT !== held)
          $display("FAIL st_hold c%0d got de=%0b adv=%0d sel=%h exp de=0 adv=0 sel=%h", c,
                   bus1.AGNT_DE_OUT, bus1.SLW_ADV_OUT, bus1.MUX_SEL_OUT, held);
        else n_pass++;
      end
      if (c == 1) begin
        held = e_sel;
        bus1.SLW_VLD_IN = 1'b0;
      end
      if (c == 4) bus1.SLW_VLD_IN = 1'b1;
    end
  endtask

  task automatic test_abort();
    do_reset();
    start_line(4'd5, 3'd2, 3'd3, 12'd4);
    bus1.SLW_VLD_IN = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      bus1.LINE_STRT_IN = 1'b0;
      n_chk++; if (bus1.AGNT_DE_OUT !== e_de) $display("FAIL ab_de c%0d got %0b exp %0b", c, bus1.AGNT_DE_OUT, e_de); else n_pass++;
      n_chk++; if (bus1.SLW_ADV_OUT !== e_adv) $display("FAIL ab_adv c%0d got %0d exp %0d", c, bus1.SLW_ADV_OUT, e_adv); else n_pass++;
      n_chk++; if (bus1.MUX_SEL_OUT !== e_sel) $display("FAIL ab_sel c%0d got %h exp %h", c, bus1.MUX_SEL_OUT, e_sel); else n_pass++;
      n_chk++; if (bus1.LINE_DONE_OUT !== e_done) $display("FAIL ab_done c%0d got %0b exp %0b", c, bus1.LINE_DONE_OUT, e_done); else n_pass++;
      if (c >= 3 && c <= 8) begin
        n_chk++; if (bus1.LINE_DONE_OUT !== 1'b0) $display("FAIL ab_no_done c%0d got %0b exp 0", c, bus1.LINE_DONE_OUT); else n_pass++;
      end
      if (c == 7) begin
        n_chk++; if (bus1.AGNT_DE_OUT !== 1'b1) $display("FAIL ab_restart got %0b exp 1", bus1.AGNT_DE_OUT); else n_pass++;
      end
      if (c == 2) bus1.CTL_RUN_IN = 1'b0;
      if (c == 3) bus1.CTL_RUN_IN = 1'b1;
      if (c == 5) start_line(4'd7, 3'd1, 3'd6, 12'd2);
    end
  endtask

  task automatic test_grp0();
    do_reset();
    start_line(4'd8, 3'd0, 3'd0, 12'd0);
    bus1.SLW_VLD_IN = 1'b1;
    tick();
    bus1.LINE_STRT_IN = 1'b0;
    n_chk++; if (bus1.LINE_DONE_OUT !== 1'b1) $display("FAIL g0_done got %0b exp 1", bus1.LINE_DONE_OUT); else n_pass++;
    n_chk++; if (bus1.AGNT_DE_OUT !== 1'b0) $display("FAIL g0_de got %0b exp 0", bus1.AGNT_DE_OUT); else n_pass++;
    tick();
    n_chk++; if (bus1.LINE_DONE_OUT !== 1'b0) $display("FAIL g0_done2 got %0b exp 0", bus1.LINE_DONE_OUT); else n_pass++;
    n_chk++; if (bus1.AGNT_DE_OUT !== 1'b0) $display("FAIL g0_de2 got %0b exp 0", bus1.AGNT_DE_OUT); else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    start_line(4'd8, 3'd0, 3'd0, 12'd5);
    bus1.SLW_VLD_IN = 1'b1;
    tick();
    bus1.LINE_STRT_IN = 1'b0;
    tick();
    tick();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (bus1.AGNT_DE_OUT !== 1'b0) $display("FAIL ar_de got %0b exp 0", bus1.AGNT_DE_OUT); else n_pass++;
    n_chk++; if (bus1.SLW_ADV_OUT !== 3'd0) $display("FAIL ar_adv got %0d exp 0", bus1.SLW_ADV_OUT); else n_pass++;
    n_chk++; if (bus1.MUX_SEL_OUT !== 64'd0) $display("FAIL ar_sel got %h exp 0", bus1.MUX_SEL_OUT); else n_pass++;
    n_chk++; if (coef1 !== 128'd0) $display("FAIL ar_coef got %h exp 0", coef1); else n_pass++;
    n_chk++; if (coef2 !== 128'd0) $display("FAIL ar_coef2 got %h exp 0", coef2); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    bus1.SLW_VLD_IN = 1'b0;
  endtask

  task automatic test_coef_dly2();
    logic [127:0] g0;
    do_reset();
    start_line(4'd6, 3'd3, 3'd5, 12'd3);
    bus1.SLW_VLD_IN = 1'b1;
    tick();
    bus1.LINE_STRT_IN = 1'b0;
    tick();
    g0 = m_cur;
    n_chk++; if (coef2 !== 128'd0) $display("FAIL d2_t0 got %h exp 0", coef2); else n_pass++;
    tick();
    n_chk++; if (coef2 !== 128'd0) $display("FAIL d2_t1 got %h exp 0", coef2); else n_pass++;
    n_chk++; if (coef1 !== g0) $display("FAIL d1_t1 got %h exp %h", coef1, g0); else n_pass++;
    tick();
    n_chk++; if (coef2 !== g0) $display("FAIL d2_t2 got %h exp %h", coef2, g0); else n_pass++;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_chk++; if (coef2 !== m_p2) $display("FAIL d2_tail c%0d got %h exp %h", c, coef2, m_p2); else n_pass++;
    end
  endtask

  task automatic test_random();
    start_line(4'($urandom_range(0, 15)), 3'($urandom), 3'($urandom), 12'($urandom_range(1, 6)));
    for (int l = 0; l < 25; l++) begin
      start_line(4'($urandom_range(0, 15)), 3'($urandom), 3'($urandom), 12'($urandom_range(0, 6)));
      for (int c = 0; c < 20; c++) begin
        bus1.SLW_VLD_IN = ($urandom_range(0, 3) != 0);
        bus1.CTL_RUN_IN = ($urandom_range(0, 49) != 0);
        tick();
        n_chk++; if (bus1.AGNT_DE_OUT !== e_de) $display("FAIL rn_de l%0d c%0d got %0b exp %0b", l, c, bus1.AGNT_DE_OUT, e_de); else n_pass++;
        n_chk++; if (bus1.SLW_ADV_OUT !== e_adv) $display("FAIL rn_adv l%0d c%0d got %0d exp %0d", l, c, bus1.SLW_ADV_OUT, e_adv); else n_pass++;
        n_chk++; if (bus1.MUX_SEL_OUT !== e_sel) $display("FAIL rn_sel l%0d c%0d got %h exp %h", l, c, bus1.MUX_SEL_OUT, e_sel); else n_pass++;
        n_chk++; if (bus1.LINE_DONE_OUT !== e_done) $display("FAIL rn_done l%0d c%0d got %0b exp %0b", l, c, bus1.LINE_DONE_OUT, e_done); else n_pass++;
        n_chk++; if (coef1 !== m_p1) $display("FAIL rn_coef l%0d c%0d got %h exp %h", l, c, coef1, m_p1); else n_pass++;
        n_chk++; if (coef2 !== m_p2) $display("FAIL rn_coef2 l%0d c%0d got %h exp %h", l, c, coef2, m_p2); else n_pass++;
        // Latched parameters must not follow the inputs mid-line; stray starts must be ignored.
        bus1.H_STEP_IN    = 4'($urandom_range(0, 15));
        bus1.H_PHASE_IN   = 3'($urandom);
        bus1.V_PHASE_IN   = 3'($urandom);
        bus1.H_GRP_IN     = 12'($urandom_range(0, 6));
        bus1.LINE_STRT_IN = ($urandom_range(0, 7) == 0);
      end
      bus1.CTL_RUN_IN = 1'b1;
    end
    bus1.LINE_STRT_IN = 1'b0;
  endtask

  initial begin
    reset_model();
    test_reset();
    test_step8();
    test_step4();
    test_step3();
    test_stall();
    test_abort();
    test_grp0();
    test_async_reset();
    test_coef_dly2();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/prt_scaler_agnt.md
Name: prt_scaler_agnt

Overview:
- Sequencing agent for the scaler kernel. Runs the horizontal phase accumulator for one output line and, per clock, produces a data-enable, sixteen 4-bit tap selects and four 32-bit packed bilinear coefficient words for the 4-pixel kernel.
- Tells the sliding-window provider how many input pixels to advance.
- Sits between the line buffer / sliding window and the kernel. Upscale only (step ≤ 1.0).

Parameters:
- P_PPC, 4: pixels per clock. Only 4 is legal; any other value is an elaboration error.
- P_GRP_W, 12: width of the output-group counter.
- P_COEF_DLY, 1: extra clocks the coefficient outputs lag MUX_SEL_OUT and AGNT_DE_OUT. Valid range 0..3.

Ports:
- CLK_IN, in, 1: clock.
- RST_IN, in, 1: reset, asynchronous, active-low.
- CTL_RUN_IN, in, 1: enable. Low aborts the line and holds IDLE.
- LINE_STRT_IN, in, 1: single-cycle pulse to start an output line.
- H_STEP_IN, in, 4: horizontal step in 1/8 input pixel, legal 1..8.
- H_PHASE_IN, in, 3: initial horizontal fraction, loaded at line start.
- V_PHASE_IN, in, 3: vertical fraction fy (line0 vs line1), loaded at line start.
- H_GRP_IN, in, P_GRP_W: number of output groups (clocks) in the line.
- SLW_VLD_IN, in, 1: sliding window holds valid data this cycle.
- SLW_ADV_OUT, out, 3: input pixels to advance the window after this group, 0..4.
- AGNT_DE_OUT, out, 1: kernel data enable.
- MUX_SEL_OUT, out, 64: 16 × 4-bit tap selects. Value 0..4 selects line0 taps A..E; 5..9 selects line1 taps F..J.
- COEF_P0_OUT .. COEF_P3_OUT, out, 32 each: byte k is coefficient c[k] for the corresponding output pixel.
- LINE_DONE_OUT, out, 1: single-cycle pulse after the last group.

Behaviour:
- Reset: all outputs are 0; state is IDLE; accumulator is 0. Coefficient delay-pipe registers are also 0.
- Step rule: H_STEP_IN = 0 or > 8 is treated as 8.
- Line-start latch: step, H_PHASE_IN (acc), V_PHASE_IN (fy) and H_GRP_IN (group count) are latched on LINE_STRT_IN in IDLE.
- States:
  - IDLE: goes to RUN on LINE_STRT_IN & CTL_RUN_IN. Exception: if H_GRP_IN = 0, pulse LINE_DONE_OUT next cycle and stay IDLE.
  - RUN: each cycle with SLW_VLD_IN = 1 issues one group and decrements the group count. Last group → DONE.
  - DONE: pulse LINE_DONE_OUT, return to IDLE.
- CTL_RUN_IN low, any state: IDLE next cycle, no LINE_DONE_OUT. AGNT_DE_OUT and SLW_ADV_OUT are 0 from that registered cycle on. Any group already in the coefficient delay pipe drains normally.
- LINE_STRT_IN outside IDLE is ignored, including when it coincides with the last group.
- Per issued group, for pixel n = 0..3:
  - p_n = acc + n·step (5 bits); tap_n = p_n[4:3] (0..3); fx_n = p_n[2:0].
  - Selects: sel[4n] = tap; sel[4n+1] = tap+1; sel[4n+2] = 5+tap; sel[4n+3] = 6+tap.
  - Weights: wx0 = 8−fx, wx1 = fx, wy0 = 8−fy, wy1 = fy.
  - Coefficients: c0 = wx0·wy0, c1 = wx1·wy0, c2 = wx0·wy1, c3 = wx1·wy1. Sum is always 64 (Q6); maximum 64 fits in 8 bits.
- Accumulator update per issued group: acc_next = acc + 4·step (≤ 39). SLW_ADV_OUT = acc_next[5:3]; acc ← acc_next[2:0].
- Stall (SLW_VLD_IN = 0 in RUN): AGNT_DE_OUT = 0, SLW_ADV_OUT = 0; acc and group count hold; MUX_SEL_OUT holds its last value.
- Latency:
  - MUX_SEL_OUT, AGNT_DE_OUT and SLW_ADV_OUT are registered, one clock after the qualifying SLW_VLD_IN cycle.
  - COEF_Px_OUT lag those by P_COEF_DLY clocks.

Decomposition:
- Package prt_scaler_pkg holds:
  - P_FRAC_W = 3 and P_COEF_ONE = 64.
  - Select constants SEL_L0_BASE = 0 and SEL_L1_BASE = 5.
  - State enum {IDLE, RUN, DONE}.
  - Struct {sel[0:3], coef[0:3]} for per-pixel results.
- Sub-module prt_scaler_agnt_phs: combinational; maps (acc, n, step, fy) to the 4 selects and 4 coefficients. Instantiated P_PPC times.

Test Plan:
- Step 8, H_PHASE 0, V_PHASE 0, H_GRP 3, SLW_VLD held 1 → three DE cycles. MUX_SEL_OUT = 0x9843_8732_7621_6510; every COEF = 0x00000040; SLW_ADV_OUT = 4; LINE_DONE_OUT pulses one cycle after the last DE.
- Step 4, phase 0, fy 0 → MUX_SEL_OUT = 0x7621_7621_6510_6510. COEF_P0 = 0x00000040, COEF_P1 = 0x00002020; SLW_ADV_OUT = 2.
- Step 3, phase 0, fy 4, H_GRP 2 → group 0: SLW_ADV 1, acc 4; group 1: SLW_ADV 2, acc 0. COEF_P0 group 0 = 0x00200020.
- Stall: SLW_VLD low for 3 cycles mid-line → DE and SLW_ADV are 0 for 3 cycles. Next group continues with unchanged acc and remaining count.
- CTL_RUN_IN dropped after group 1 of 4 → IDLE, no LINE_DONE_OUT; a new LINE_STRT_IN then restarts cleanly. Separately, H_GRP = 0 → LINE_DONE_OUT only, no DE.
- RST_IN asserted mid-RUN → all outputs 0 asynchronously. P_COEF_DLY = 2 → COEF trails DE by exactly 2 clocks.
